// File: rtl/sar_adc_ctrl_if.sv
// Handshake/bus bundle between a SAR sequencer and its host/analog front end.
// Host (master) drives enable, start and the raw comparator; the sequencer (slave) drives the rest.
interface sar_adc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             cmp_in;
    logic             sample_en;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output ena, start, cmp_in,
        input  sample_en, dac_code, busy, done, result
    );

    modport slave (
        input  ena, start, cmp_in,
        output sample_en, dac_code, busy, done, result
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: track phase, then one settle+decide slot per bit, result/done out of DONE.
// Latency 1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1) clocks from start; no backpressure, start ignored while busy.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_adc_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0]       SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic             done_q, done_d;
    logic             sample_en_q, sample_en_d;
    logic             busy_q, busy_d;
    logic             cmp_meta_q, cmp_s_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    trial_d = MSB_ONLY;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DECIDE: begin
                trial_d[idx_q] = cmp_s_q;
                if (idx_q != '0) begin
                    trial_d[idx_q - 1'b1] = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = trial_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything, including the result commit in DONE.
        if (!bus.ena) begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            trial_d  = '0;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        sample_en_d = (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        if (state_d == IDLE || state_d == DONE) begin
            dac_d = result_d;
        end else if (state_d == SAMPLE) begin
            dac_d = '0;
        end else begin
            dac_d = trial_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            trial_q     <= '0;
            result_q    <= '0;
            dac_q       <= '0;
            done_q      <= 1'b0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            cmp_meta_q  <= 1'b0;
            cmp_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            trial_q     <= trial_d;
            result_q    <= result_d;
            dac_q       <= dac_d;
            done_q      <= done_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
            cmp_meta_q  <= bus.cmp_in;
            cmp_s_q     <= cmp_meta_q;
        end
    end

    assign bus.sample_en = sample_en_q;
    assign bus.dac_code  = dac_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomized bench for sar_adc_ctrl against a binary-search reference model.
module tb_sar_adc_ctrl;
    localparam int W    = 8;
    localparam int S    = 4;
    localparam int T    = 3;
    localparam int LAT  = 1 + S + W * (T + 1);
    localparam int HIST = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sar_adc_ctrl_if #(.WIDTH(W)) bus ();

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         cmp_mode;
    logic [7:0] vin;
    assign bus.cmp_in = (cmp_mode == 1) ? 1'b1 :
                        (cmp_mode == 2) ? 1'b0 : (vin >= bus.dac_code);

    int errors = 0;
    int checks = 0;

    int edge_cnt = 0;
    int e0 = 0;
    bit mon_on = 1'b0;
    logic [7:0] dac_h [HIST];
    logic [7:0] res_h [HIST];
    logic       se_h  [HIST];
    logic       done_h[HIST];
    logic       busy_h[HIST];

    logic [7:0] exp_trial[W];
    logic [7:0] exp_res;
    logic [7:0] last_res;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        int k;
        if (mon_on) begin
            k = edge_cnt - e0;
            if (k >= 0 && k < HIST) begin
                dac_h[k]  = bus.dac_code;
                res_h[k]  = bus.result;
                se_h[k]   = bus.sample_en;
                done_h[k] = bus.done;
                busy_h[k] = bus.busy;
            end
        end
    end

    // Reference: plain successive approximation over an ideal comparator.
    task automatic model(input int mode, input logic [7:0] v);
        logic [7:0] code;
        logic [7:0] t;
        logic       keep;
        code = 8'h00;
        for (int b = W - 1; b >= 0; b--) begin
            t = code | (8'h01 << b);
            exp_trial[W-1-b] = t;
            keep = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (v >= t);
            if (keep) code = t;
        end
        exp_res = code;
    endtask

    task automatic launch(input bit hold);
        mon_on = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            dac_h[i] = '0; res_h[i] = '0; se_h[i] = 1'b0; done_h[i] = 1'b0; busy_h[i] = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        mon_on = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_k(input int k);
        forever begin
            @(negedge clk);
            #1;
            if (edge_cnt - e0 >= k) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.start = 1'b0;
        cmp_mode = 0;
        vin = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.sample_en !== 1'b0) begin errors++; $display("FAIL reset_sample_en: got %b want 0", bus.sample_en); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.dac_code !== 8'h00) begin errors++; $display("FAIL reset_dac: got %h want 00", bus.dac_code); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", bus.result); end
        rst_n = 1'b1;
        last_res = 8'h00;
    endtask

    task automatic test_conversion(input logic [7:0] v, input int mode, input string nm);
        int se_cnt;
        int dn_cnt;
        int slot;
        vin = v;
        cmp_mode = mode;
        model(mode, v);
        launch(1'b0);
        wait_k(LAT + 3);
        se_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i <= LAT + 3; i++) begin
            se_cnt += int'(se_h[i]);
            dn_cnt += int'(done_h[i]);
        end
        checks++; if (se_cnt != S) begin errors++; $display("FAIL %s_sample_len: got %0d want %0d", nm, se_cnt, S); end
        for (int i = 0; i < S; i++) begin
            checks++; if (se_h[i] !== 1'b1 || dac_h[i] !== 8'h00) begin errors++; $display("FAIL %s_track c%0d: se=%b dac=%h want se=1 dac=00", nm, i, se_h[i], dac_h[i]); end
        end
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j <= T; j++) begin
                slot = S + i * (T + 1) + j;
                checks++; if (dac_h[slot] !== exp_trial[i]) begin errors++; $display("FAIL %s_trial%0d c%0d: got %h want %h", nm, i, slot, dac_h[slot], exp_trial[i]); end
            end
        end
        checks++; if (dn_cnt != 1 || done_h[LAT] !== 1'b1) begin errors++; $display("FAIL %s_done: pulses=%0d at_lat=%b want 1 pulse at c%0d", nm, dn_cnt, done_h[LAT], LAT); end
        checks++; if (res_h[LAT] !== exp_res) begin errors++; $display("FAIL %s_result: got %h want %h", nm, res_h[LAT], exp_res); end
        checks++; if (dac_h[LAT] !== exp_res) begin errors++; $display("FAIL %s_idle_dac: got %h want %h", nm, dac_h[LAT], exp_res); end
        checks++; if (busy_h[LAT-1] !== 1'b1 || busy_h[LAT] !== 1'b0) begin errors++; $display("FAIL %s_busy_edge: got %b%b want 10", nm, busy_h[LAT-1], busy_h[LAT]); end
        last_res = exp_res;
    endtask

    task automatic test_start_ignored();
        int se_cnt;
        int dn_cnt;
        vin = 8'h3C;
        cmp_mode = 0;
        model(0, vin);
        launch(1'b0);
        wait_k(10);
        bus.start = 1'b1;
        wait_k(11);
        bus.start = 1'b0;
        wait_k(90);
        se_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i <= 90; i++) begin
            se_cnt += int'(se_h[i]);
            dn_cnt += int'(done_h[i]);
        end
        checks++; if (dn_cnt != 1 || done_h[LAT] !== 1'b1) begin errors++; $display("FAIL busy_start_done: pulses=%0d at_lat=%b want 1 at c%0d", dn_cnt, done_h[LAT], LAT); end
        checks++; if (se_cnt != S) begin errors++; $display("FAIL busy_start_sample: got %0d want %0d", se_cnt, S); end
        checks++; if (res_h[LAT] !== 8'h3C) begin errors++; $display("FAIL busy_start_result: got %h want 3c", res_h[LAT]); end
        last_res = exp_res;
    endtask

    task automatic test_ena_abort();
        int dn_cnt;
        vin = 8'h55;
        cmp_mode = 0;
        launch(1'b0);
        wait_k(20);
        bus.ena = 1'b0;
        wait_k(21);
        bus.ena = 1'b1;
        checks++; if (busy_h[21] !== 1'b0 || se_h[21] !== 1'b0) begin errors++; $display("FAIL ena_idle: busy=%b se=%b want 0 0", busy_h[21], se_h[21]); end
        checks++; if (dac_h[21] !== last_res) begin errors++; $display("FAIL ena_idle_dac: got %h want %h", dac_h[21], last_res); end
        wait_k(60);
        dn_cnt = 0;
        for (int i = 0; i <= 60; i++) dn_cnt += int'(done_h[i]);
        checks++; if (dn_cnt != 0) begin errors++; $display("FAIL ena_no_done: got %0d want 0", dn_cnt); end
        checks++; if (res_h[60] !== last_res) begin errors++; $display("FAIL ena_result_kept: got %h want %h", res_h[60], last_res); end
        test_conversion(8'h55, 0, "ena_restart");
    endtask

    task automatic test_reset_mid();
        int dn_cnt;
        vin = 8'h01;
        cmp_mode = 0;
        launch(1'b0);
        wait_k(15);
        rst_n = 1'b0;
        wait_k(16);
        rst_n = 1'b1;
        checks++; if ({busy_h[16], se_h[16], done_h[16]} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b%b%b want 000", busy_h[16], se_h[16], done_h[16]); end
        checks++; if (dac_h[16] !== 8'h00 || res_h[16] !== 8'h00) begin errors++; $display("FAIL rst_mid_bus: dac=%h res=%h want 00 00", dac_h[16], res_h[16]); end
        wait_k(60);
        dn_cnt = 0;
        for (int i = 0; i <= 60; i++) dn_cnt += int'(done_h[i]);
        checks++; if (dn_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", dn_cnt); end
        last_res = 8'h00;
        test_conversion(8'h01, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        int pos[$];
        vin = 8'h7E;
        cmp_mode = 0;
        launch(1'b1);
        wait_k(100);
        bus.start = 1'b0;
        for (int i = 0; i <= 100; i++) if (done_h[i] === 1'b1) pos.push_back(i);
        checks++; if (pos.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", pos.size()); end
        else begin
            checks++; if (pos[0] != LAT || pos[1] != LAT + LAT + 1) begin errors++; $display("FAIL b2b_spacing: got c%0d c%0d want c%0d c%0d", pos[0], pos[1], LAT, 2 * LAT + 1); end
        end
        checks++; if (res_h[LAT] !== 8'h7E || res_h[2*LAT+1] !== 8'h7E) begin errors++; $display("FAIL b2b_result: got %h %h want 7e 7e", res_h[LAT], res_h[2*LAT+1]); end
        wait_k(100 + LAT + 5);
        checks++; if (bus.busy !== 1'b0 || bus.result !== 8'h7E) begin errors++; $display("FAIL b2b_drain: busy=%b res=%h want 0 7e", bus.busy, bus.result); end
        last_res = 8'h7E;
    endtask

    initial begin
        test_reset();
        test_conversion(8'hA5, 0, "vin_a5");
        test_conversion(8'h00, 1, "tied_one");
        test_conversion(8'h00, 2, "tied_zero");
        for (int r = 0; r < 5; r++) test_conversion(8'($urandom_range(0, 255)), 0, "random");
        test_start_ignored();
        test_ena_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: conversion resolution in bits.
REQ-002 Parameter SAMPLE_CYCLES, default 4: length of the track phase in clocks; legal range 1..15.
REQ-003 Parameter SETTLE_CYCLES, default 3: DAC/comparator settle clocks per bit; legal range 2..15.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 ena  input  1  block enable; low aborts any activity.
REQ-007 start  input  1  conversion request, level-sampled, accepted only in IDLE.
REQ-008 cmp_in  input  1  asynchronous comparator output; 1 means Vin >= Vdac.
REQ-009 sample_en  output  1  track/hold switch control; 1 means track.
REQ-010 dac_code  output  WIDTH  trial code driven to the external DAC.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when result is updated.
REQ-013 result  output  WIDTH  last completed conversion.

Function
REQ-014 cmp_in SHALL pass through a 2-flop synchronizer; only the synchronized value cmp_s is used.
REQ-015 FSM states SHALL be IDLE, SAMPLE, SETTLE, DECIDE and DONE.
REQ-016 In IDLE with ena=1 and start=1, the next state SHALL be SAMPLE, with the phase counter loaded to SAMPLE_CYCLES-1.
REQ-017 SAMPLE SHALL hold sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES clocks, then go to SETTLE.
REQ-018 On leaving SAMPLE: trial register = MSB only set (0x80 at WIDTH=8), bit index = WIDTH-1, settle counter = SETTLE_CYCLES-1.
REQ-019 SETTLE SHALL drive dac_code = trial register for SETTLE_CYCLES clocks, then go to DECIDE.
REQ-020 DECIDE SHALL last one clock and update the current bit from cmp_s:
- cmp_s=1: keep the bit.
- cmp_s=0: clear the bit.
REQ-021 In DECIDE at bit index > 0, the FSM SHALL set the next lower bit, decrement the index, reload the settle counter, and go to SETTLE.
REQ-022 In DECIDE at bit index 0, the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one clock:
- load result with the final trial register;
- assert done=1;
- next state IDLE.
REQ-024 Latency: done SHALL be high exactly 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) clocks after the edge that samples start (37 with defaults).
REQ-025 sample_en SHALL be 0 in every state except SAMPLE.
REQ-026 In IDLE and DONE, dac_code SHALL equal result.
REQ-027 start while busy=1 SHALL be ignored (no queuing, no restart).
REQ-028 start held high continuously SHALL start a new conversion on the first IDLE cycle after DONE (back-to-back, one IDLE cycle between conversions).
REQ-029 ena=0 in any state SHALL force IDLE on the next edge. Effects:
- result is not updated;
- done is not asserted;
- trial register is cleared.
REQ-030 ena=0 in the same cycle as start=1 in IDLE SHALL not start a conversion.
REQ-031 done SHALL never be high for two consecutive cycles.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set the following on that edge, regardless of state:
- state = IDLE;
- sample_en = 0, busy = 0, done = 0;
- dac_code = 0, result = 0;
- trial register and counters = 0;
- synchronizer flops = 0.
REQ-033 Reset asserted mid-conversion SHALL discard the conversion with no done pulse; the first start after release SHALL convert normally.

Verification
REQ-034 Comparator model Vin = 0xA5 (cmp_in = Vin >= dac_code); pulse start -> sample_en high for 4 cycles, dac_code trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; done at cycle 37; result = 0xA5.
REQ-035 cmp_in tied 1 -> result 0xFF; cmp_in tied 0 -> result 0x00; each with a single done pulse at cycle 37.
REQ-036 Pulse start at cycle 10 of a busy conversion with Vin = 0x3C -> only one done pulse; result = 0x3C; no second sample phase.
REQ-037 Drop ena for 1 cycle at cycle 20 of a conversion with Vin = 0x55 -> IDLE next cycle; no done; result keeps its prior value; a fresh start gives 0x55.
REQ-038 Assert rst_n=0 at cycle 15 of a conversion -> all outputs 0 on the next edge; after release, start with Vin = 0x01 -> result 0x01 at cycle 37.
REQ-039 Hold start high with Vin = 0x7E -> consecutive done pulses 38 cycles apart, each with result 0x7E.
